tx_frame_ctrl: RTL and testbench

//  Transmit sequencer between inFIFO and msk_modulator. On a start request it emits a

---
 rtl/tx_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_tx_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_ctrl.sv
// rtl/tx_frame_ctrl.sv - transmit sequencer: preamble, per-bit FIFO fetch, modulator handshake
module tx_frame_ctrl #(
  parameter int LEN_W         = 11,
  parameter int PREAMBLE_BITS = 32,
  parameter int TIMEOUT       = 255
) (
  input  logic             inClock,
  input  logic             inReset,
  input  logic             inStart,
  input  logic [LEN_W-1:0] inFrameLen,
  input  logic             inAbort,
  input  logic             inFifoEmpty,
  input  logic             inFifoData,
  output logic             outFifoReadEnable,
  input  logic             inCoderReady,
  output logic             outCoderData,
  output logic             outCoderEmpty,
  output logic             outBusy,
  output logic             outDone,
  output logic             outUnderrun
);

  // Preamble counter must be able to hold PREAMBLE_BITS itself; +2 keeps the width >= 1 when it is 0.
  localparam int PRE_W = $clog2(PREAMBLE_BITS + 2);
  localparam int EMP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    FETCH,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t           state, stateNext;
  logic [LEN_W-1:0] remCnt, remNext;
  logic [PRE_W-1:0] preCnt, preNext;
  logic [EMP_W-1:0] emptyCnt, emptyNext;
  logic             bitReg, bitNext;

  logic readEn, coderEmpty, coderData, done, underrun;

  // State and counter registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge inClock) begin
    if (!inReset) begin
      state    <= IDLE;
      remCnt   <= '0;
      preCnt   <= '0;
      emptyCnt <= '0;
      bitReg   <= 1'b0;
    end else begin
      state    <= stateNext;
      remCnt   <= remNext;
      preCnt   <= preNext;
      emptyCnt <= emptyNext;
      bitReg   <= bitNext;
    end
  end

  // Next-state, counter updates and handshake outputs; abort and reset override last.
  always_comb begin
    stateNext  = state;
    remNext    = remCnt;
    preNext    = preCnt;
    emptyNext  = emptyCnt;
    bitNext    = bitReg;
    readEn     = 1'b0;
    coderEmpty = 1'b1;
    coderData  = 1'b0;
    done       = 1'b0;
    underrun   = 1'b0;

    case (state)
      IDLE: begin
        preNext   = '0;
        emptyNext = '0;
        if (inStart && (inFrameLen != '0)) begin
          remNext   = inFrameLen;
          stateNext = (PREAMBLE_BITS == 0) ? FETCH : PREAMBLE;
        end
      end
      PREAMBLE: begin
        coderEmpty = 1'b0;
        if (inCoderReady) begin
          preNext = preCnt + 1'b1;
          if ((preCnt + 1'b1) == PRE_W'(PREAMBLE_BITS)) begin
            stateNext = FETCH;
          end
        end
      end
      FETCH: begin
        if (!inFifoEmpty) begin
          readEn    = 1'b1;
          emptyNext = '0;
          stateNext = LOAD;
        end else if (emptyCnt == EMP_W'(TIMEOUT - 1)) begin
          underrun  = 1'b1;
          emptyNext = EMP_W'(TIMEOUT);
          stateNext = IDLE;
        end else begin
          emptyNext = emptyCnt + 1'b1;
        end
      end
      LOAD: begin
        bitNext   = inFifoData;
        stateNext = SEND;
      end
      SEND: begin
        coderEmpty = 1'b0;
        coderData  = bitReg;
        if (inCoderReady) begin
          remNext   = remCnt - LEN_W'(1);
          stateNext = (remCnt == LEN_W'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // Abort wins over any same-cycle consumption or FIFO read: nothing advances.
    if (inAbort && (state != IDLE)) begin
      stateNext = IDLE;
      remNext   = remCnt;
      preNext   = preCnt;
      emptyNext = emptyCnt;
      bitNext   = bitReg;
      readEn    = 1'b0;
      done      = 1'b0;
      underrun  = 1'b0;
    end

    // While reset is held the outputs already show their idle values, so no read fires on the reset edge.
    if (!inReset) begin
      readEn     = 1'b0;
      coderEmpty = 1'b1;
      coderData  = 1'b0;
      done       = 1'b0;
      underrun   = 1'b0;
    end
  end

  assign outFifoReadEnable = readEn;
  assign outCoderEmpty     = coderEmpty;
  assign outCoderData      = coderData;
  assign outDone           = done;
  assign outUnderrun       = underrun;
  assign outBusy           = inReset && (state != IDLE);

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb/tb_tx_frame_ctrl.sv - self-checking bench for tx_frame_ctrl
module tb_tx_frame_ctrl;

  localparam int LEN_W = 11;
  localparam int PRE   = 4;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             inReset = 1'b0;
  logic             inStart = 1'b0;
  logic [LEN_W-1:0] inFrameLen = '0;
  logic             inAbort = 1'b0;
  logic             inFifoEmpty = 1'b1;
  logic             inFifoData = 1'b0;
  logic             inCoderReady = 1'b0;
  logic             outFifoReadEnable, outCoderData, outCoderEmpty;
  logic             outBusy, outDone, outUnderrun;

  tx_frame_ctrl #(.LEN_W(LEN_W), .PREAMBLE_BITS(PRE), .TIMEOUT(TMO)) dut (
    .inClock(clk), .inReset(inReset), .inStart(inStart), .inFrameLen(inFrameLen),
    .inAbort(inAbort), .inFifoEmpty(inFifoEmpty), .inFifoData(inFifoData),
    .outFifoReadEnable(outFifoReadEnable), .inCoderReady(inCoderReady),
    .outCoderData(outCoderData), .outCoderEmpty(outCoderEmpty), .outBusy(outBusy),
    .outDone(outDone), .outUnderrun(outUnderrun)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit fifoMem [64];
  int fifoWr = 0, fifoRd = 0;
  bit expBits [256];
  int expWr = 0, expRd = 0;
  int nReads = 0, nDone = 0, nUnder = 0;
  int cyc = 0, lastConsumeCyc = 0, underrunCyc = 0;
  bit doneBusy = 1'b0, reNow = 1'b0, strobeOn = 1'b0;
  int r0, d0, u0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic pushFifo(input bit b);
    fifoMem[fifoWr] = b;
    fifoWr++;
    inFifoEmpty = 1'b0;
  endtask

  task automatic pushExp(input bit b);
    expBits[expWr] = b;
    expWr++;
  endtask

  task automatic pushPreamble();
    for (int i = 0; i < PRE; i++) pushExp(1'b0);
  endtask

  // Per-cycle compare against the scoreboard of expected modulator bits and event counts.
  task automatic monitor();
    reNow = 1'b0;
    if (!inReset) begin
      check("rst_re", outFifoReadEnable, 0);
      check("rst_data", outCoderData, 0);
      check("rst_empty", outCoderEmpty, 1);
      check("rst_busy", outBusy, 0);
      check("rst_done", outDone, 0);
      check("rst_under", outUnderrun, 0);
    end else begin
      if (inCoderReady && !outCoderEmpty && !inAbort) begin
        if (expRd < expWr) begin
          check("bit", outCoderData, expBits[expRd]);
          expRd++;
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit: got bit %0d required no bit offered", outCoderData);
        end
        lastConsumeCyc = cyc;
      end
      if (outFifoReadEnable) begin
        check("read_nonempty", inFifoEmpty, 0);
        nReads++;
        reNow = 1'b1;
      end
      if (outDone) begin
        nDone++;
        doneBusy = outBusy;
      end
      if (outUnderrun) begin
        nUnder++;
        underrunCyc = cyc;
      end
      if (!outBusy) begin
        check("idle_empty", outCoderEmpty, 1);
        check("idle_re", outFifoReadEnable, 0);
      end
    end
  endtask

  // One clock: compare at the falling edge, then update FIFO model and ready strobe after the rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (reNow && (fifoRd < fifoWr)) begin
      inFifoData = fifoMem[fifoRd];
      fifoRd++;
    end
    inFifoEmpty = (fifoRd == fifoWr);
    cyc++;
    if (strobeOn) inCoderReady = ((cyc % 4) == 3);
  endtask

  task automatic startFrame(input int len);
    inFrameLen = LEN_W'(len);
    inStart = 1'b1;
    step();
    inStart = 1'b0;
  endtask

  // which: 0 = done pulses, 1 = underrun pulses, 2 = read pulses
  task automatic waitEvt(input int which, input int target, input string name);
    int v;
    v = 0;
    for (int i = 0; i < 500; i++) begin
      v = (which == 0) ? nDone : (which == 1) ? nUnder : nReads;
      if (v >= target) break;
      step();
    end
    v = (which == 0) ? nDone : (which == 1) ? nUnder : nReads;
    check(name, (v >= target) ? 1 : 0, 1);
  endtask

  initial begin
    // 1: reset held with start asserted
    inStart = 1'b1;
    inFrameLen = LEN_W'(5);
    for (int i = 0; i < 3; i++) step();
    inStart = 1'b0;
    inReset = 1'b1;
    step();
    check("t1_busy", outBusy, 0);
    check("t1_reads", nReads, 0);

    // 2: nominal frame, preamble 4 then 1,0,1
    strobeOn = 1'b1;
    pushFifo(1'b1); pushFifo(1'b0); pushFifo(1'b1);
    pushPreamble();
    pushExp(1'b1); pushExp(1'b0); pushExp(1'b1);
    r0 = nReads; d0 = nDone;
    startFrame(3);
    waitEvt(0, d0 + 1, "t2_done_seen");
    check("t2_busy_during_done", doneBusy, 1);
    check("t2_busy_after_done", outBusy, 0);
    check("t2_reads", nReads - r0, 3);
    check("t2_bits_all", expRd, expWr);
    check("t2_bits_count", expWr, 7);
    step();
    check("t2_done_once", nDone - d0, 1);

    // 3: underrun with 2 of 4 bits available
    pushFifo(1'b1); pushFifo(1'b0);
    pushPreamble();
    pushExp(1'b1); pushExp(1'b0);
    r0 = nReads; d0 = nDone; u0 = nUnder;
    startFrame(4);
    waitEvt(1, u0 + 1, "t3_under_seen");
    check("t3_under_gap", underrunCyc - lastConsumeCyc, TMO);
    check("t3_busy", outBusy, 0);
    for (int i = 0; i < 4; i++) step();
    check("t3_under_once", nUnder - u0, 1);
    check("t3_no_done", nDone - d0, 0);
    check("t3_reads", nReads - r0, 2);
    check("t3_bits_all", expRd, expWr);

    // 4: zero-length start ignored; start during SEND ignored
    startFrame(0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_len0_busy", outBusy, 0);
    end
    pushFifo(1'b1); pushFifo(1'b1); pushFifo(1'b0);
    pushPreamble();
    pushExp(1'b1); pushExp(1'b1);
    r0 = nReads; d0 = nDone;
    startFrame(2);
    waitEvt(2, r0 + 1, "t4_first_read");
    step();
    check("t4_in_send", outCoderEmpty, 0);
    startFrame(7);
    waitEvt(0, d0 + 1, "t4_done_seen");
    check("t4_reads", nReads - r0, 2);
    check("t4_fifo_left", fifoWr - fifoRd, 1);
    check("t4_bits_all", expRd, expWr);

    // 5: abort in preamble with a same-cycle ready strobe
    strobeOn = 1'b0;
    inCoderReady = 1'b0;
    pushExp(1'b0);
    r0 = nReads; d0 = nDone; u0 = nUnder;
    startFrame(1);
    inCoderReady = 1'b1;
    step();
    inCoderReady = 1'b0;
    step();
    inCoderReady = 1'b1;
    inAbort = 1'b1;
    step();
    inCoderReady = 1'b0;
    inAbort = 1'b0;
    check("t5_busy", outBusy, 0);
    check("t5_empty", outCoderEmpty, 1);
    check("t5_bits_all", expRd, expWr);
    step();
    check("t5_no_done", nDone - d0, 0);
    check("t5_no_under", nUnder - u0, 0);
    check("t5_no_read", nReads - r0, 0);
    pushPreamble();
    pushExp(1'b0);
    strobeOn = 1'b1;
    startFrame(1);
    waitEvt(0, d0 + 1, "t5_restart_done");
    check("t5_restart_bits", expRd, expWr);
    check("t5_fifo_drained", fifoWr - fifoRd, 0);

    // 6: reset while in SEND, then a clean one-bit frame
    pushFifo(1'b1); pushFifo(1'b0);
    pushPreamble();
    r0 = nReads; d0 = nDone;
    startFrame(2);
    waitEvt(2, r0 + 1, "t6_first_read");
    step();
    check("t6_in_send", outCoderEmpty, 0);
    inReset = 1'b0;
    step();
    inReset = 1'b1;
    check("t6_busy", outBusy, 0);
    check("t6_fifo_left", fifoWr - fifoRd, 1);
    check("t6_bits_so_far", expRd, expWr);
    pushPreamble();
    pushExp(1'b0);
    startFrame(1);
    waitEvt(0, d0 + 1, "t6_done_seen");
    check("t6_done_once", nDone - d0, 1);
    check("t6_reads", nReads - r0, 2);
    check("t6_bits_all", expRd, expWr);
    check("t6_fifo_drained", fifoWr - fifoRd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
